// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer for the EX stage.
// Iterative shift-add multiply or restoring divide over XLEN cycles, with stall, flush and a done pulse.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Start,
    input  logic [2:0]      Op,
    input  logic [XLEN-1:0] Src1,
    input  logic [XLEN-1:0] Src2,
    input  logic            Flush,
    output logic            Stall,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_next;

    // opa_q: multiplier (multiply) or dividend/quotient (divide)
    // opb_q: multiplicand (multiply) or divisor in the low half (divide)
    // acc_q: product (multiply) or remainder in the low half (divide)
    logic [2:0]        op_q;
    logic [CW-1:0]     count;
    logic [XLEN-1:0]   opa_q;
    logic [2*XLEN-1:0] opb_q;
    logic [2*XLEN-1:0] acc_q;
    logic              neg_q;
    logic              neg_rem_q;
    logic              dz_q;

    logic              s1_signed, s2_signed;
    logic              neg1, neg2;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     shifted;
    logic              sub_ok;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        s1_signed = (Op == 3'b001) || (Op == 3'b010) || (Op == 3'b100) || (Op == 3'b110);
        s2_signed = (Op == 3'b001) || (Op == 3'b100) || (Op == 3'b110);
        neg1      = s1_signed & Src1[XLEN-1];
        neg2      = s2_signed & Src2[XLEN-1];
        mag1      = neg1 ? -Src1 : Src1;
        mag2      = neg2 ? -Src2 : Src2;
    end

    always_comb begin
        shifted = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
        sub_ok  = shifted >= {1'b0, opb_q[XLEN-1:0]};
    end

    // Divide by zero leaves the dividend magnitude in the remainder; restoring the
    // dividend's sign reproduces Src1 exactly, so only the quotient needs an override.
    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quot = dz_q ? '1 : (neg_q ? -opa_q : opa_q);
        rem  = neg_rem_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        case (op_q)
            3'b000:                 fix_result = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_result = quot;
            default:                fix_result = rem;
        endcase
    end

    always_comb begin
        state_next = state;
        Stall      = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = CALC;
                    Stall      = 1'b1;
                end
            end
            CALC: begin
                Stall = 1'b1;
                if (count == CW'(XLEN - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                Stall      = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Flush overrides everything decided above, in every state.
        if (Flush) begin
            state_next = IDLE;
            Stall      = 1'b0;
            Done       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            count     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            Result    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (Start && !Flush) begin
                        op_q      <= Op;
                        count     <= '0;
                        acc_q     <= '0;
                        neg_q     <= neg1 ^ neg2;
                        neg_rem_q <= neg1;
                        dz_q      <= (Src2 == '0);
                        if (Op[2]) begin
                            opa_q <= mag1;
                            opb_q <= {{XLEN{1'b0}}, mag2};
                        end else begin
                            opa_q <= mag2;
                            opb_q <= {{XLEN{1'b0}}, mag1};
                        end
                    end
                end
                CALC: begin
                    count <= count + CW'(1);
                    if (op_q[2]) begin
                        if (sub_ok) begin
                            acc_q[XLEN-1:0] <= shifted[XLEN-1:0] - opb_q[XLEN-1:0];
                            opa_q           <= {opa_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_q[XLEN-1:0] <= shifted[XLEN-1:0];
                            opa_q           <= {opa_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        if (opa_q[0]) begin
                            acc_q <= acc_q + opb_q;
                        end
                        opb_q <= opb_q << 1;
                        opa_q <= opa_q >> 1;
                    end
                end
                FIX: begin
                    if (!Flush) begin
                        Result <= fix_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
